// File: rtl/axi_tdd_ng_counter_mp.sv
// Multi-profile TDD frame counter: startup delay, a per-frame sequence
// of frame lengths, burst counting, graceful stop and resync.
module axi_tdd_ng_counter_mp #(
    parameter int REGISTER_WIDTH    = 32,
    parameter int BURST_COUNT_WIDTH = 32,
    parameter int NUM_PROFILES      = 4,
    parameter int PROFILE_WIDTH     = $clog2(NUM_PROFILES + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   tdd_enable,
    input  logic                                   tdd_sync,
    input  logic                                   tdd_sync_rst,
    input  logic                                   tdd_stop,
    input  logic [BURST_COUNT_WIDTH-1:0]           asy_tdd_burst_count,
    input  logic [REGISTER_WIDTH-1:0]              asy_tdd_startup_delay,
    input  logic [NUM_PROFILES*REGISTER_WIDTH-1:0] asy_tdd_frame_length,
    input  logic [PROFILE_WIDTH-1:0]               asy_tdd_profile_count,
    output logic [REGISTER_WIDTH-1:0]              tdd_counter,
    output logic [1:0]                             tdd_cstate,
    output logic [PROFILE_WIDTH-1:0]               tdd_profile,
    output logic [BURST_COUNT_WIDTH-1:0]           tdd_burst_counter,
    output logic                                   tdd_endof_frame,
    output logic                                   tdd_endof_burst,
    output logic                                   tdd_sync_ignored
);

    localparam int RW = REGISTER_WIDTH;
    localparam int BW = BURST_COUNT_WIDTH;
    localparam int PW = PROFILE_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_WAITING = 2'd2,
        S_RUNNING = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] len_q, len_d;
    logic [RW-1:0] dly_q, dly_d;
    logic [PW-1:0] prof_q, prof_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          stop_q, stop_d;
    logic          eof_q, eof_d;
    logic          eob_q, eob_d;
    logic          ign_q, ign_d;

    logic [PW-1:0] peff;
    logic [PW-1:0] prof_nx;
    logic [RW-1:0] len_first;
    logic [RW-1:0] len_nx;

    // Clamp the profile count into 1..NUM_PROFILES and pick the next index
    always_comb begin
        peff = asy_tdd_profile_count;
        if (asy_tdd_profile_count == '0)
            peff = PW'(1);
        else if (asy_tdd_profile_count > PW'(NUM_PROFILES))
            peff = PW'(NUM_PROFILES);
        if (prof_q + PW'(1) >= peff)
            prof_nx = '0;
        else
            prof_nx = prof_q + PW'(1);
    end

    // Length of profile 0 and of the next profile; a zero length reads as 1
    always_comb begin
        len_first = asy_tdd_frame_length[RW-1:0];
        len_nx    = len_first;
        for (int i = 0; i < NUM_PROFILES; i++) begin
            if (prof_nx == PW'(i))
                len_nx = asy_tdd_frame_length[i*RW +: RW];
        end
        if (len_first == '0)
            len_first = RW'(1);
        if (len_nx == '0)
            len_nx = RW'(1);
    end

    // Next-state logic; the end-of pulses are precomputed for the next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        dly_d   = dly_q;
        prof_d  = prof_q;
        burst_d = burst_q;
        stop_d  = stop_q;
        ign_d   = 1'b0;
        if (!tdd_enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            len_d   = '0;
            dly_d   = '0;
            prof_d  = '0;
            burst_d = '0;
            stop_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_ARMED: begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                    prof_d  = '0;
                    stop_d  = 1'b0;
                    burst_d = asy_tdd_burst_count;
                    if (state_q == S_ARMED && tdd_sync) begin
                        dly_d = asy_tdd_startup_delay;
                        len_d = len_first;
                        if (asy_tdd_startup_delay == '0)
                            state_d = S_RUNNING;
                        else
                            state_d = S_WAITING;
                    end
                end
                S_WAITING, S_RUNNING: begin
                    if (tdd_sync && tdd_sync_rst) begin
                        cnt_d   = '0;
                        prof_d  = '0;
                        stop_d  = 1'b0;
                        burst_d = asy_tdd_burst_count;
                        dly_d   = asy_tdd_startup_delay;
                        len_d   = len_first;
                        if (asy_tdd_startup_delay == '0)
                            state_d = S_RUNNING;
                        else
                            state_d = S_WAITING;
                    end else begin
                        ign_d = tdd_sync;
                        if (state_q == S_WAITING) begin
                            if (tdd_stop) begin
                                state_d = S_ARMED;
                                cnt_d   = '0;
                                prof_d  = '0;
                                stop_d  = 1'b0;
                                burst_d = asy_tdd_burst_count;
                            end else if (cnt_q == dly_q - RW'(1)) begin
                                state_d = S_RUNNING;
                                cnt_d   = '0;
                                len_d   = len_first;
                            end else begin
                                cnt_d = cnt_q + RW'(1);
                            end
                        end else if (cnt_q == len_q - RW'(1)) begin
                            if (burst_q == BW'(1) || stop_q || tdd_stop) begin
                                state_d = S_ARMED;
                                cnt_d   = '0;
                                prof_d  = '0;
                                stop_d  = 1'b0;
                                burst_d = asy_tdd_burst_count;
                            end else begin
                                cnt_d  = '0;
                                prof_d = prof_nx;
                                len_d  = len_nx;
                                if (burst_q != '0)
                                    burst_d = burst_q - BW'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + RW'(1);
                            if (tdd_stop)
                                stop_d = 1'b1;
                        end
                    end
                end
            endcase
        end
        eof_d = (state_d == S_RUNNING) && (cnt_d == len_d - RW'(1));
        eob_d = eof_d && ((burst_d == BW'(1)) || stop_d);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            dly_q   <= '0;
            prof_q  <= '0;
            burst_q <= '0;
            stop_q  <= 1'b0;
            eof_q   <= 1'b0;
            eob_q   <= 1'b0;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            dly_q   <= dly_d;
            prof_q  <= prof_d;
            burst_q <= burst_d;
            stop_q  <= stop_d;
            eof_q   <= eof_d;
            eob_q   <= eob_d;
            ign_q   <= ign_d;
        end
    end

    assign tdd_counter       = cnt_q;
    assign tdd_cstate        = state_q;
    assign tdd_profile       = prof_q;
    assign tdd_burst_counter = burst_q;
    assign tdd_endof_frame   = eof_q;
    assign tdd_endof_burst   = eob_q;
    assign tdd_sync_ignored  = ign_q;

endmodule

// File: tb/tb_axi_tdd_ng_counter_mp.sv
// Directed bench for axi_tdd_ng_counter_mp: a vector table for the
// basic burst plus hand sequences for stop, resync, clamps and resets.
module tb_axi_tdd_ng_counter_mp;

    localparam int RW = 32;
    localparam int BW = 32;
    localparam int NP = 4;
    localparam int PW = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic              clk = 1'b0;
    logic              rst;
    logic              tdd_enable;
    logic              tdd_sync;
    logic              tdd_sync_rst;
    logic              tdd_stop;
    logic [BW-1:0]     asy_tdd_burst_count;
    logic [RW-1:0]     asy_tdd_startup_delay;
    logic [NP*RW-1:0]  asy_tdd_frame_length;
    logic [PW-1:0]     asy_tdd_profile_count;
    logic [RW-1:0]     tdd_counter;
    logic [1:0]        tdd_cstate;
    logic [PW-1:0]     tdd_profile;
    logic [BW-1:0]     tdd_burst_counter;
    logic              tdd_endof_frame;
    logic              tdd_endof_burst;
    logic              tdd_sync_ignored;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       sync;
        logic       stop;
        logic [1:0] st;
        int         cnt;
        int         prof;
        int         burst;
        logic       eof;
        logic       eob;
    } vec_t;

    vec_t tbl[14];

    axi_tdd_ng_counter_mp #(
        .REGISTER_WIDTH(RW),
        .BURST_COUNT_WIDTH(BW),
        .NUM_PROFILES(NP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tdd_enable(tdd_enable),
        .tdd_sync(tdd_sync),
        .tdd_sync_rst(tdd_sync_rst),
        .tdd_stop(tdd_stop),
        .asy_tdd_burst_count(asy_tdd_burst_count),
        .asy_tdd_startup_delay(asy_tdd_startup_delay),
        .asy_tdd_frame_length(asy_tdd_frame_length),
        .asy_tdd_profile_count(asy_tdd_profile_count),
        .tdd_counter(tdd_counter),
        .tdd_cstate(tdd_cstate),
        .tdd_profile(tdd_profile),
        .tdd_burst_counter(tdd_burst_counter),
        .tdd_endof_frame(tdd_endof_frame),
        .tdd_endof_burst(tdd_endof_burst),
        .tdd_sync_ignored(tdd_sync_ignored)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [1:0] st, input int c,
                       input int p, input int b, input logic eof,
                       input logic eob, input logic ign);
        n_total++;
        if (tdd_cstate !== st || tdd_counter !== RW'(c) ||
            tdd_profile !== PW'(p) || tdd_burst_counter !== BW'(b) ||
            tdd_endof_frame !== eof || tdd_endof_burst !== eob ||
            tdd_sync_ignored !== ign) begin
            $display("FAIL %s: got st=%0d cnt=%0d prof=%0d burst=%0d eof=%b eob=%b ign=%b, want st=%0d cnt=%0d prof=%0d burst=%0d eof=%b eob=%b ign=%b",
                     nm, tdd_cstate, tdd_counter, tdd_profile,
                     tdd_burst_counter, tdd_endof_frame, tdd_endof_burst,
                     tdd_sync_ignored, st, c, p, b, eof, eob, ign);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_len(input int l0, input int l1, input int l2, input int l3);
        asy_tdd_frame_length = {RW'(l3), RW'(l2), RW'(l1), RW'(l0)};
    endtask

    task automatic cfg(input int b, input int d, input int p);
        asy_tdd_burst_count   = BW'(b);
        asy_tdd_startup_delay = RW'(d);
        asy_tdd_profile_count = PW'(p);
    endtask

    // drop enable to IDLE then re-enable into ARMED
    task automatic rearm(input string nm, input int b);
        tdd_enable = 1'b0;
        step();
        chk({nm, "_idle"}, ST_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tdd_enable = 1'b1;
        step();
        chk({nm, "_armed"}, ST_ARM, 0, 0, b, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        tdd_enable = 1'b0;
        tdd_sync = 1'b0;
        tdd_sync_rst = 1'b0;
        tdd_stop = 1'b0;
        cfg(2, 2, 3);
        set_len(4, 6, 5, 0);

        tbl[0]  = '{1'b0, 1'b0, ST_ARM,  0, 0, 2, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, ST_WAIT, 0, 0, 2, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, ST_WAIT, 1, 0, 2, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, ST_RUN,  0, 0, 2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, ST_RUN,  1, 0, 2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, ST_RUN,  2, 0, 2, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, ST_RUN,  3, 0, 2, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, ST_RUN,  0, 1, 1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, ST_RUN,  1, 1, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, ST_RUN,  2, 1, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, ST_RUN,  3, 1, 1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, ST_RUN,  4, 1, 1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, ST_RUN,  5, 1, 1, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, ST_ARM,  0, 0, 2, 1'b0, 1'b0};

        repeat (2) step();
        chk("reset", ST_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk("idle_no_enable", ST_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // basic burst: P=3, L={4,6,5}, D=2, burst=2
        tdd_enable = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tdd_sync = tbl[i].sync;
            tdd_stop = tbl[i].stop;
            step();
            chk($sformatf("burst_row%0d", i), tbl[i].st, tbl[i].cnt,
                tbl[i].prof, tbl[i].burst, tbl[i].eof, tbl[i].eob, 1'b0);
        end
        tdd_sync = 1'b0;
        tdd_stop = 1'b0;

        // infinite burst, D=0, 55 frames of 3 cycles
        cfg(0, 0, 2);
        set_len(3, 3, 0, 0);
        step();
        chk("inf_armed", ST_ARM, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 165; i++) begin
            tdd_sync = (i == 0);
            step();
            chk($sformatf("inf_c%0d", i), ST_RUN, i % 3, (i / 3) % 2, 0,
                (i % 3) == 2, 1'b0, 1'b0);
        end
        tdd_sync = 1'b0;
        // stop on the last cycle of a frame ends it there
        tdd_stop = 1'b1;
        step();
        tdd_stop = 1'b0;
        chk("stop_last_cycle", ST_ARM, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // graceful stop in cycle 2 of a 10-cycle profile-1 frame
        cfg(0, 0, 2);
        set_len(2, 10, 0, 0);
        rearm("stop", 0);
        tdd_sync = 1'b1;
        step();
        tdd_sync = 1'b0;
        chk("stop_f0c0", ST_RUN, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        step();
        chk("stop_f0c1", ST_RUN, 1, 0, 0, 1'b1, 1'b0, 1'b0);
        step();
        chk("stop_f1c0", ST_RUN, 0, 1, 0, 1'b0, 1'b0, 1'b0);
        step();
        chk("stop_f1c1", ST_RUN, 1, 1, 0, 1'b0, 1'b0, 1'b0);
        tdd_stop = 1'b1;
        step();
        tdd_stop = 1'b0;
        chk("stop_f1c2", ST_RUN, 2, 1, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i < 9; i++) begin
            step();
            chk($sformatf("stop_f1c%0d", i), ST_RUN, i, 1, 0, 1'b0, 1'b0, 1'b0);
        end
        step();
        chk("stop_end", ST_RUN, 9, 1, 0, 1'b1, 1'b1, 1'b0);
        step();
        chk("stop_armed", ST_ARM, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tdd_sync = 1'b1;
        step();
        tdd_sync = 1'b0;
        chk("stop_resync", ST_RUN, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        step();
        chk("stop_resync_len", ST_RUN, 1, 0, 0, 1'b1, 1'b0, 1'b0);

        // sync restart and ignored sync, P=2, L={3,10}, D=2, burst=5
        cfg(5, 2, 2);
        set_len(3, 10, 0, 0);
        rearm("rs", 5);
        tdd_sync = 1'b1;
        step();
        tdd_sync = 1'b0;
        chk("rs_wait0", ST_WAIT, 0, 0, 5, 1'b0, 1'b0, 1'b0);
        step();
        chk("rs_wait1", ST_WAIT, 1, 0, 5, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("rs_f0_end", ST_RUN, 2, 0, 5, 1'b1, 1'b0, 1'b0);
        step();
        chk("rs_f1c0", ST_RUN, 0, 1, 4, 1'b0, 1'b0, 1'b0);
        repeat (7) step();
        chk("rs_f1c7", ST_RUN, 7, 1, 4, 1'b0, 1'b0, 1'b0);
        asy_tdd_burst_count = BW'(6);
        tdd_sync = 1'b1;
        tdd_sync_rst = 1'b1;
        step();
        tdd_sync = 1'b0;
        tdd_sync_rst = 1'b0;
        chk("rs_restart", ST_WAIT, 0, 0, 6, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rs_run0", ST_RUN, 0, 0, 6, 1'b0, 1'b0, 1'b0);
        tdd_sync = 1'b1;
        step();
        tdd_sync = 1'b0;
        chk("rs_ignored", ST_RUN, 1, 0, 6, 1'b0, 1'b0, 1'b1);
        step();
        chk("rs_ign_once", ST_RUN, 2, 0, 6, 1'b1, 1'b0, 1'b0);
        step();
        chk("rs_continue", ST_RUN, 0, 1, 5, 1'b0, 1'b0, 1'b0);

        // stop in WAITING, then enable drop in WAITING
        cfg(1, 3, 1);
        rearm("wt", 1);
        tdd_sync = 1'b1;
        step();
        tdd_sync = 1'b0;
        chk("wt_wait", ST_WAIT, 0, 0, 1, 1'b0, 1'b0, 1'b0);
        tdd_stop = 1'b1;
        step();
        tdd_stop = 1'b0;
        chk("wt_stop", ST_ARM, 0, 0, 1, 1'b0, 1'b0, 1'b0);
        tdd_sync = 1'b1;
        step();
        tdd_sync = 1'b0;
        step();
        chk("wt_wait1", ST_WAIT, 1, 0, 1, 1'b0, 1'b0, 1'b0);
        tdd_enable = 1'b0;
        step();
        chk("wt_disable", ST_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // zero lengths and profile count clamps
        cfg(3, 0, 0);
        set_len(0, 0, 0, 0);
        rearm("z", 3);
        tdd_sync = 1'b1;
        step();
        tdd_sync = 1'b0;
        chk("z_f0", ST_RUN, 0, 0, 3, 1'b1, 1'b0, 1'b0);
        step();
        chk("z_f1", ST_RUN, 0, 0, 2, 1'b1, 1'b0, 1'b0);
        step();
        chk("z_f2", ST_RUN, 0, 0, 1, 1'b1, 1'b1, 1'b0);
        step();
        chk("z_armed", ST_ARM, 0, 0, 3, 1'b0, 1'b0, 1'b0);
        cfg(0, 0, 7);
        step();
        chk("z_reload", ST_ARM, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tdd_sync = 1'b1;
        step();
        tdd_sync = 1'b0;
        chk("clamp_p0", ST_RUN, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++) begin
            step();
            chk($sformatf("clamp_f%0d", i), ST_RUN, 0, i % 4, 0,
                1'b1, 1'b0, 1'b0);
        end

        // asynchronous reset mid-RUNNING
        rst = 1'b1;
        #1;
        chk("async_rst", ST_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tdd_enable = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle", ST_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tdd_enable = 1'b1;
        step();
        chk("post_rst_armed", ST_ARM, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tdd_sync = 1'b1;
        step();
        tdd_sync = 1'b0;
        chk("post_rst_run", ST_RUN, 0, 0, 0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_tdd_ng_counter_mp.md
# axi_tdd_ng_counter_mp

Multi-profile TDD frame counter: the timing core of the next-generation TDD controller. It replaces a single frame length with a per-frame sequence of up to NUM_PROFILES lengths and adds a graceful stop request, a resynchronising sync, and burst/profile status outputs. It sits between the sync/enable logic and the per-channel on/off comparators, which consume `tdd_counter`, `tdd_profile` and `tdd_endof_frame`.

## Interface
- REGISTER_WIDTH, 32, width of counter, delay and each frame length
- BURST_COUNT_WIDTH, 32, width of burst count
- NUM_PROFILES, 4, frame-length table depth, legal range 1..16
- PROFILE_WIDTH, $clog2(NUM_PROFILES+1), derived, width of profile index/count
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- tdd_enable  in  1  run enable, level
- tdd_sync  in  1  sync pulse
- tdd_sync_rst  in  1  when high, a sync in WAITING/RUNNING restarts the sequence
- tdd_stop  in  1  graceful stop request, pulse
- asy_tdd_burst_count  in  BURST_COUNT_WIDTH  frames per burst; 0 = infinite
- asy_tdd_startup_delay  in  REGISTER_WIDTH  cycles between sync and first frame
- asy_tdd_frame_length  in  NUM_PROFILES*REGISTER_WIDTH  length of profile p at [p*REGISTER_WIDTH +: REGISTER_WIDTH]
- asy_tdd_profile_count  in  PROFILE_WIDTH  profiles in sequence; 0 → 1, values > NUM_PROFILES → NUM_PROFILES
- tdd_counter  out  REGISTER_WIDTH  delay/frame counter
- tdd_cstate  out  2  state: IDLE=0, ARMED=1, WAITING=2, RUNNING=3
- tdd_profile  out  PROFILE_WIDTH  profile index of the current frame
- tdd_burst_counter  out  BURST_COUNT_WIDTH  frames remaining, including the current one
- tdd_endof_frame  out  1  high during the last cycle of every frame
- tdd_endof_burst  out  1  high during the last cycle of a burst or of a graceful stop
- tdd_sync_ignored  out  1  one-cycle pulse: sync seen in WAITING/RUNNING with tdd_sync_rst=0

## Operation
- Reset values (on rst and when tdd_enable=0, synchronously):
  - all outputs are 0 and the state is IDLE;
  - the stop-pending flag is cleared.
- L_p = asy_tdd_frame_length[p]; a value of 0 is treated as 1.
- D = asy_tdd_startup_delay. P = effective profile count.
- IDLE → ARMED on the first cycle with tdd_enable=1.
- On entering ARMED:
  - tdd_counter, tdd_profile and stop-pending are set to 0;
  - tdd_burst_counter loads asy_tdd_burst_count every ARMED cycle.
- ARMED + tdd_sync → WAITING, or → RUNNING when D=0.
- WAITING: counter counts 0..D-1, then goes to RUNNING with counter=0.
- RUNNING: counter counts 0..L_p-1. On the cycle where counter==L_p-1, `tdd_endof_frame`=1, and the next cycle is one of:
  - last frame (tdd_burst_counter==1, or stop-pending): `tdd_endof_burst`=1 on the same cycle, next state ARMED;
  - otherwise: counter=0, profile=(p+1) mod P, burst_counter decremented unless it is 0 (infinite).
- tdd_stop:
  - in RUNNING it sets stop-pending, which takes effect at the end of the current frame;
  - in WAITING it returns to ARMED next cycle with no endof pulses;
  - in IDLE/ARMED it is ignored.
- tdd_sync && tdd_sync_rst in WAITING/RUNNING restarts as if ARMED had seen the sync:
  - counter=0, profile=0, burst reloaded, stop-pending cleared;
  - no endof pulses are generated.
- tdd_sync in WAITING/RUNNING with tdd_sync_rst=0: no effect on counting; `tdd_sync_ignored` pulses.
- Simultaneous events, in priority order:
  1. rst;
  2. tdd_enable=0;
  3. sync-restart (overrides endof_frame and stop);
  4. end of frame;
  5. tdd_stop.
- tdd_stop on the last cycle of a frame ends that frame as the stop frame.
- `asy_*` inputs are quasi-static:
  - L_p and P are sampled at each frame start;
  - D is sampled at sync;
  - changes mid-frame take effect at the next sample point.
- All counters wrap modulo 2^width only in the case of mis-programming; there is no saturation logic.

## Timing
- tdd_enable rising at cycle t: ARMED at t+1.
- Sync at cycle t in ARMED: WAITING with counter=0 at t+1; RUNNING at t+1+D.
- Frame with profile p occupies exactly L_p cycles; the endof pulses are 1 cycle wide.
- All outputs are registered; no combinational path from any input to any output.
- rst asserted mid-frame: outputs go to 0 immediately (asynchronously). The block resumes in IDLE at the first clock edge after rst deasserts.

## Test plan
- P=3, L={4,6,5}, D=2, burst=2; sync at t0:
  - WAITING for 2 cycles;
  - frames of 4 then 6 cycles with profile 0 then 1;
  - `tdd_endof_burst` on the 6th cycle of frame 2, then ARMED.
- burst=0, P=2, L={3,3}, D=0: RUNNING directly after sync; profile toggles every 3 cycles for more than 50 frames; burst_counter stays 0.
- tdd_stop pulse in cycle 2 of a frame with L=10: the frame completes all 10 cycles, then `tdd_endof_burst`=1 and ARMED; a later sync starts at profile 0.
- sync with sync_rst=1 at counter=7 of frame 2 (P=2): next cycle counter=0, profile=0, WAITING, burst reloaded; with sync_rst=0 instead, counting continues and `tdd_sync_ignored` pulses once.
- L_p=0 and profile_count=0 / >NUM_PROFILES: 1-cycle frames with `tdd_endof_frame` held high; profile clamps correctly.
- rst asserted mid-RUNNING, and separately tdd_enable dropped mid-WAITING: all outputs 0, state IDLE; the block re-arms normally afterwards.
